// File: rtl/nn_layer_sequencer.sv
// Forward-pass sequencer for the two-layer network: steps node/input counters,
// emits flat weight indices and the MAC clear/enable/writeback strobes.
//
// state   | meaning
// IDLE    | waiting for start, all outputs low
// H_CLR   | clear accumulator for hidden node node_idx
// H_MAC   | accumulate hidden input in_idx (stalls while hold_q)
// H_STORE | write back hidden node node_idx
// O_CLR   | clear accumulator for output node node_idx
// O_MAC   | accumulate output input in_idx (stalls while hold_q)
// O_STORE | write back output node node_idx
// DONE    | one-cycle completion pulse
module nn_layer_sequencer #(
    parameter int INPUT_COUNT   = 62,
    parameter int H_NODE_NUMBER = 20,
    parameter int O_NODE_NUMBER = 10
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic        hold,
    output logic        busy,
    output logic        done,
    output logic        layer_sel,
    output logic [4:0]  node_idx,
    output logic [5:0]  in_idx,
    output logic [10:0] w_idx,
    output logic        acc_clr,
    output logic        mac_en,
    output logic        node_wr
);

    typedef enum logic [2:0] {
        IDLE, H_CLR, H_MAC, H_STORE, O_CLR, O_MAC, O_STORE, DONE
    } state_t;

    localparam logic [5:0]  H_IN_LAST   = 6'(INPUT_COUNT - 1);
    localparam logic [5:0]  O_IN_LAST   = 6'(H_NODE_NUMBER - 1);
    localparam logic [4:0]  H_NODE_LAST = 5'(H_NODE_NUMBER - 1);
    localparam logic [4:0]  O_NODE_LAST = 5'(O_NODE_NUMBER - 1);
    localparam logic [10:0] H_STRIDE    = 11'(INPUT_COUNT);
    localparam logic [10:0] O_STRIDE    = 11'(H_NODE_NUMBER);

    state_t     state_q, state_d;
    logic [4:0] node_q, node_d;
    logic [5:0] in_q, in_d;
    logic       hold_q;
    logic       mac_q, mac_d;

    assign mac_q = (state_q == H_MAC) || (state_q == O_MAC);
    assign mac_d = (state_d == H_MAC) || (state_d == O_MAC);

    // hold is registered so every output stays a pure decode of registers:
    // a hold seen in a MAC cycle stalls the following MAC cycle.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            node_q  <= '0;
            in_q    <= '0;
            hold_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            node_q  <= node_d;
            in_q    <= in_d;
            hold_q  <= hold && mac_q && mac_d;
        end
    end

    always_comb begin
        state_d = state_q;
        node_d  = node_q;
        in_d    = in_q;
        case (state_q)
            IDLE: begin
                if (start) begin
                    state_d = H_CLR;
                    node_d  = '0;
                    in_d    = '0;
                end
            end
            H_CLR: state_d = H_MAC;
            H_MAC: begin
                if (!hold_q) begin
                    if (in_q == H_IN_LAST) begin
                        in_d    = '0;
                        state_d = H_STORE;
                    end else begin
                        in_d = in_q + 6'd1;
                    end
                end
            end
            H_STORE: begin
                if (node_q == H_NODE_LAST) begin
                    node_d  = '0;
                    state_d = O_CLR;
                end else begin
                    node_d  = node_q + 5'd1;
                    state_d = H_CLR;
                end
            end
            O_CLR: state_d = O_MAC;
            O_MAC: begin
                if (!hold_q) begin
                    if (in_q == O_IN_LAST) begin
                        in_d    = '0;
                        state_d = O_STORE;
                    end else begin
                        in_d = in_q + 6'd1;
                    end
                end
            end
            O_STORE: begin
                if (node_q == O_NODE_LAST) begin
                    node_d  = '0;
                    state_d = DONE;
                end else begin
                    node_d  = node_q + 5'd1;
                    state_d = O_CLR;
                end
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        busy      = (state_q != IDLE);
        done      = (state_q == DONE);
        layer_sel = (state_q == O_CLR) || (state_q == O_MAC) || (state_q == O_STORE);
        acc_clr   = (state_q == H_CLR) || (state_q == O_CLR);
        mac_en    = mac_q && !hold_q;
        node_wr   = (state_q == H_STORE) || (state_q == O_STORE);
        node_idx  = node_q;
        in_idx    = in_q;
        w_idx     = 11'(node_q) * (layer_sel ? O_STRIDE : H_STRIDE) + 11'(in_q);
    end

endmodule
